// File: rtl/ldtu_gsel_pkg.sv
// Shared definitions for the LiTe-DTU look-ahead gain selector: mode codes,
// width helpers and per-channel slice addressing.
package ldtu_gsel_pkg;

  typedef enum logic [1:0] {
    MODE_AUTO     = 2'b00,
    MODE_FORCE    = 2'b01,
    MODE_NOPOST   = 2'b10,
    MODE_AUTO_ALT = 2'b11
  } mode_e;

  localparam int NB_DEFAULT      = 12;
  localparam int BL_BITS_DEFAULT = 6;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  // Gain-id width never drops below one bit, even for a single channel.
  function automatic int gid_width(input int ngain);
    return (clog2(ngain) < 1) ? 1 : clog2(ngain);
  endfunction

  function automatic int chan_lsb(input int c, input int nb);
    return c * nb;
  endfunction

endpackage

// File: rtl/ldtu_lookahead_gsel_if.sv
// Sample stream into the selector and gain-tagged word out to the encoder.
interface ldtu_lookahead_gsel_if
  import ldtu_gsel_pkg::*;
#(
  parameter int NGAIN = 2,
  parameter int NB    = NB_DEFAULT,
  parameter int GW    = gid_width(NGAIN)
);
  logic                  din_valid;
  logic [NGAIN*NB-1:0]   din;
  logic                  dout_valid;
  logic [NB+GW-1:0]      dout;
  logic                  baseline_flag;

  modport master (output din_valid, din, input dout_valid, dout, baseline_flag);
  modport slave  (input din_valid, din, output dout_valid, dout, baseline_flag);
endinterface

// File: rtl/ldtu_sat_hold_cnt.sv
// Per-channel saturation hold counter: keeps a channel blocked for the
// look-ahead plus post-saturation window after its last saturating sample.
module ldtu_sat_hold_cnt
  import ldtu_gsel_pkg::*;
#(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          sat,
  input  logic          emit,
  input  logic [CW-1:0] load_val,
  output logic          blocked
);

  logic [CW-1:0] cnt;

  // A fresh saturation reloads the full window; only emissions consume it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (sat) begin
      cnt <= load_val;
    end else if (emit && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign blocked = sat || (cnt != '0);

endmodule

// File: rtl/ldtu_lookahead_gsel.sv
// Look-ahead circular buffer with per-sample gain selection for LiTe-DTU.
// Emits sample j-PRE when sample j arrives, tagged with the chosen gain.
module ldtu_lookahead_gsel
  import ldtu_gsel_pkg::*;
#(
  parameter int NGAIN   = 2,
  parameter int NB      = NB_DEFAULT,
  parameter int GW      = gid_width(NGAIN),
  parameter int DEPTH   = 16,
  parameter int PW      = 4,
  parameter int BL_BITS = BL_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic [GW-1:0]       force_gain,
  input  logic [PW-1:0]       win_pre,
  input  logic [PW-1:0]       win_post,
  input  logic [NGAIN*NB-1:0] sat_thr,
  ldtu_lookahead_gsel_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = PW + 2;

  logic [PW-1:0]       pre_q;
  logic [PW-1:0]       post_q;
  logic [PW-1:0]       fill_q;
  logic [PW-1:0]       pre_clip;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [NGAIN*NB-1:0] mem [DEPTH];
  logic [NGAIN*NB-1:0] rd_word;
  logic                emit;
  logic                is_force;
  logic                is_nopost;
  logic [CW-1:0]       load_val;
  logic [NGAIN-2:0]    sat;
  logic [NGAIN-2:0]    blocked;
  logic [GW-1:0]       gain_sel;
  logic [NB-1:0]       sample;
  logic                bl_next;
  logic                unused_last_thr;

  assign is_force  = (mode == MODE_FORCE);
  assign is_nopost = (mode == MODE_NOPOST);
  assign pre_clip  = (int'(win_pre) > DEPTH - 1) ? PW'(DEPTH - 1) : win_pre;
  assign emit      = bus.din_valid && (fill_q == pre_q);
  assign rd_ptr    = wr_ptr - AW'(pre_q);
  assign load_val  = CW'(pre_q) + (is_nopost ? CW'(0) : CW'(post_q));

  // With no look-ahead the read slot is the one being written, so bypass.
  assign rd_word   = (pre_q == '0) ? bus.din : mem[rd_ptr];

  // The lowest-gain channel is the fallback and never needs a threshold.
  assign unused_last_thr = ^sat_thr[chan_lsb(NGAIN-1, NB) +: NB];

  always_comb begin
    sat = '0;
    for (int c = 0; c < NGAIN - 1; c++) begin
      sat[c] = bus.din_valid &&
               (bus.din[chan_lsb(c, NB) +: NB] >= sat_thr[chan_lsb(c, NB) +: NB]);
    end
  end

  for (genvar c = 0; c < NGAIN - 1; c++) begin : g_hold
    ldtu_sat_hold_cnt #(.CW(CW)) u_hold (
      .clk      (clk),
      .reset    (reset),
      .clear    (is_force),
      .sat      (sat[c]),
      .emit     (emit),
      .load_val (load_val),
      .blocked  (blocked[c])
    );
  end

  // Highest-gain unblocked channel wins; forced ids beyond range clamp down.
  always_comb begin
    gain_sel = GW'(NGAIN - 1);
    if (is_force) begin
      if (int'(force_gain) < NGAIN) gain_sel = force_gain;
    end else begin
      for (int c = NGAIN - 2; c >= 0; c--) begin
        if (!blocked[c]) gain_sel = GW'(c);
      end
    end
  end

  assign sample  = rd_word[chan_lsb(int'(gain_sel), NB) +: NB];
  assign bl_next = (sample[NB-1:BL_BITS] == '0) && (is_force || (gain_sel == '0));

  always_ff @(posedge clk) begin
    if (bus.din_valid) mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q             <= pre_clip;
      post_q            <= win_post;
      wr_ptr            <= '0;
      fill_q            <= '0;
      bus.dout_valid    <= 1'b0;
      bus.dout          <= '0;
      bus.baseline_flag <= 1'b0;
    end else begin
      bus.dout_valid <= emit;
      if (bus.din_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (!emit) fill_q <= fill_q + 1'b1;
      end
      if (emit) begin
        bus.dout          <= {gain_sel, sample};
        bus.baseline_flag <= bl_next;
      end
    end
  end

endmodule

// File: tb/tb_ldtu_lookahead_gsel.sv
// Drives a 2-gain/depth-16 and a 3-gain/depth-8 selector with the same
// stream and compares both against a window-based reference model.
module tb_ldtu_lookahead_gsel;
  import ldtu_gsel_pkg::*;

  localparam int NB = 12;

  typedef struct packed {
    logic [35:0] d;
    logic [2:0]  sat;
    logic        frc;
  } samp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [1:0]  force_gain;
  logic [3:0]  win_pre;
  logic [3:0]  win_post;
  logic [35:0] sat_thr;
  logic        din_valid;
  logic [35:0] din;

  samp_t hist[$];
  int    pre_m[2];
  int    pe_m;
  int    ng_m[2] = '{2, 3};
  int    checks = 0;
  int    passes = 0;

  always #5 clk = ~clk;

  ldtu_lookahead_gsel_if #(.NGAIN(2), .NB(NB), .GW(1)) bus2();
  ldtu_lookahead_gsel_if #(.NGAIN(3), .NB(NB), .GW(2)) bus3();

  assign bus2.din_valid = din_valid;
  assign bus2.din       = din[23:0];
  assign bus3.din_valid = din_valid;
  assign bus3.din       = din;

  ldtu_lookahead_gsel #(.NGAIN(2), .NB(NB), .GW(1), .DEPTH(16), .PW(4), .BL_BITS(6)) dut2 (
    .clk(clk), .reset(reset), .mode(mode), .force_gain(force_gain[0]),
    .win_pre(win_pre), .win_post(win_post), .sat_thr(sat_thr[23:0]), .bus(bus2)
  );

  ldtu_lookahead_gsel #(.NGAIN(3), .NB(NB), .GW(2), .DEPTH(8), .PW(4), .BL_BITS(6)) dut3 (
    .clk(clk), .reset(reset), .mode(mode), .force_gain(force_gain),
    .win_pre(win_pre), .win_post(win_post), .sat_thr(sat_thr), .bus(bus3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Saturation at s covers samples s-PRE..s+POST; a fill-phase saturation
  // covers 0..PRE+POST-1; any FORCE sample on the way cancels the hold.
  function automatic bit chanBlocked(int di, int c, int k);
    int pre = pre_m[di];
    int e   = k + pre;
    for (int s = e; s >= 0; s--) begin
      if (hist[s].frc) return 1'b0;
      if (hist[s].sat[c]) begin
        if (s < pre) begin
          if (k < pre + pe_m) return 1'b1;
        end else if ((k >= s - pre) && (k <= s + pe_m)) begin
          return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  function automatic int expGain(int di, int k);
    int ng = ng_m[di];
    int f;
    if (mode == MODE_FORCE) begin
      f = (di == 0) ? int'(force_gain[0]) : int'(force_gain);
      return (f >= ng) ? ng - 1 : f;
    end
    for (int c = 0; c < ng - 1; c++) begin
      if (!chanBlocked(di, c, k)) return c;
    end
    return ng - 1;
  endfunction

  task automatic doReset(input int pre, input int post, input logic [1:0] m,
                         input logic [1:0] fg, input logic [35:0] thr);
    @(negedge clk);
    reset = 1'b1; din_valid = 1'b0; win_pre = 4'(pre); win_post = 4'(post);
    mode = m; force_gain = fg; sat_thr = thr;
    @(posedge clk); #1;
    checkOutput("rst g2 valid", 32'(bus2.dout_valid), 32'd0);
    checkOutput("rst g2 dout", 32'(bus2.dout), 32'd0);
    checkOutput("rst g2 bl", 32'(bus2.baseline_flag), 32'd0);
    checkOutput("rst g3 valid", 32'(bus3.dout_valid), 32'd0);
    checkOutput("rst g3 dout", 32'(bus3.dout), 32'd0);
    checkOutput("rst g3 bl", 32'(bus3.baseline_flag), 32'd0);
    hist.delete();
    pre_m[0] = (pre > 15) ? 15 : pre;
    pre_m[1] = (pre > 7) ? 7 : pre;
    pe_m     = (m == MODE_NOPOST) ? 0 : post;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input bit v, input logic [35:0] d);
    samp_t       ns;
    int          j, k, g;
    bit          ev;
    logic [11:0] smp;
    logic [31:0] ov, od, ob;
    @(negedge clk);
    din_valid = v; din = d;
    @(posedge clk); #1;
    if (v) begin
      ns.d   = d;
      ns.frc = (mode == MODE_FORCE);
      for (int c = 0; c < 3; c++) ns.sat[c] = (d[c*NB +: NB] >= sat_thr[c*NB +: NB]);
      hist.push_back(ns);
    end
    j = hist.size() - 1;
    for (int di = 0; di < 2; di++) begin
      ov = (di == 0) ? 32'(bus2.dout_valid) : 32'(bus3.dout_valid);
      od = (di == 0) ? 32'(bus2.dout) : 32'(bus3.dout);
      ob = (di == 0) ? 32'(bus2.baseline_flag) : 32'(bus3.baseline_flag);
      ev = v && (j >= pre_m[di]);
      checkOutput($sformatf("g%0d valid s%0d", ng_m[di], j), ov, 32'(ev));
      if (ev) begin
        k   = j - pre_m[di];
        g   = expGain(di, k);
        smp = hist[k].d[g*NB +: NB];
        checkOutput($sformatf("g%0d dout k%0d", ng_m[di], k), od, (32'(g) << NB) | 32'(smp));
        checkOutput($sformatf("g%0d bl k%0d", ng_m[di], k), ob,
                    32'((smp < 12'd64) && ((mode == MODE_FORCE) || (g == 0))));
      end
    end
  endtask

  function automatic logic [11:0] rndChan();
    case ($urandom_range(0, 3))
      0:       return 12'($urandom_range(0, 63));
      1:       return 12'($urandom_range(12'hC00, 12'hFFF));
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    reset = 1'b1; din_valid = 1'b0; din = '0; mode = MODE_AUTO;
    force_gain = '0; win_pre = '0; win_post = '0; sat_thr = '1;

    // Quiet stream: gain 0 and baseline once the window has filled.
    doReset(3, 4, MODE_AUTO, 2'd0, {3{12'hFFF}});
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, {rndChan(), 12'h100, 12'h020});

    // Single and back-to-back saturation on the high-gain channel.
    doReset(3, 4, MODE_AUTO, 2'd0, {3{12'hFFF}});
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, {12'h300, 12'(12'h100 + i), (i == 10) ? 12'hFFF : 12'h020});
    doReset(3, 4, MODE_AUTO, 2'd0, {3{12'hFFF}});
    for (int i = 0; i < 22; i++)
      applyStimulus(1'b1, {12'h300, 12'(12'h100 + i), (i == 10 || i == 13) ? 12'hFFF : 12'h020});

    // Forced gain ignores saturation, then AUTO resumes with idle counters.
    doReset(3, 4, MODE_FORCE, 2'd1, {3{12'hFFF}});
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, {12'h222, 12'h015, 12'hFFF});
    mode = MODE_AUTO;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, {12'h222, 12'h015, 12'h030});

    // Two channels saturate together without post-hold.
    doReset(2, 5, MODE_NOPOST, 2'd0, {12'hFFF, 12'h800, 12'h800});
    for (int i = 0; i < 26; i++)
      applyStimulus(1'b1, {12'(12'h200 + i), (i == 20) ? 12'h900 : 12'h010,
                           (i == 20) ? 12'h900 : 12'h010});

    // Reset pulse mid-stream restarts the fill phase.
    doReset(3, 4, MODE_AUTO, 2'd0, {3{12'hFFF}});
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, {12'h011, 12'h022, 12'(12'h040 + i)});
    doReset(3, 4, MODE_AUTO, 2'd0, {3{12'hFFF}});
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, {12'h011, 12'h022, 12'(12'h050 + i)});

    // Randomised segments: zero look-ahead first, then random windows/modes.
    for (int seg = 0; seg < 8; seg++) begin
      doReset((seg == 0) ? 0 : $urandom_range(0, 15), $urandom_range(0, 15),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              {12'($urandom_range(12'hA00, 12'hFFF)), 12'($urandom_range(12'hA00, 12'hFFF)),
               12'($urandom_range(12'hA00, 12'hFFF))});
      for (int i = 0; i < 60; i++)
        applyStimulus($urandom_range(0, 4) != 0, {rndChan(), rndChan(), rndChan()});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
